// File: rtl/floppy_drive_mech.sv
// floppy_drive_mech: 3.5" Mac drive mechanics: IWM register decode, head stepping, rotation address, sense bits
module floppy_drive_mech #(
  parameter int BYTE_CYCLES = 128,
  parameter int STEP_CYCLES = 96000,
  parameter int MAX_TRACK   = 79,
  parameter int TACH_BYTES  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ca,
  input  logic        sel,
  input  logic        lstrb,
  input  logic        enable,
  input  logic        inserted,
  input  logic        sides,
  input  logic        ready,
  input  logic        wr_protect,
  input  logic [3:0]  spt,
  output logic [6:0]  track,
  output logic        side,
  output logic        eject,
  output logic        motor,
  output logic [13:0] addr,
  output logic        sense
);
  localparam int BW = $clog2(BYTE_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int TW = $clog2(TACH_BYTES + 1);
  logic          lstrb_q, lstrb_qq, dir, step_busy, tach;
  logic [BW-1:0] byte_cnt;
  logic [SW-1:0] step_cnt;
  logic [TW-1:0] tach_cnt;
  logic          stb, spin, adv, do_step;
  logic [2:0]    reg_sel;
  logic [13:0]   lim;
  logic [6:0]    track_nxt;
  logic [15:0]   sv;
  always_comb begin
    reg_sel   = {ca[1], ca[0], sel};
    stb       = lstrb_q & ~lstrb_qq & enable;
    do_step   = stb && reg_sel == 3'b001 && !ca[2] && !step_busy;
    spin      = motor & inserted;
    adv       = spin && byte_cnt == BW'(BYTE_CYCLES - 1);
    lim       = {1'b0, spt, 9'd0};
    track_nxt = dir ? (track != 7'd0 ? track - 7'd1 : track)
                    : (track < 7'(MAX_TRACK) ? track + 7'd1 : track);
    sv        = {1'b1, 1'b1, 1'b0, ~ready, 1'b1, 1'b1, sides, 1'b1,
                 tach, 1'b1, track != 7'd0, ~motor, ~wr_protect, ~step_busy, ~inserted, dir};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lstrb_q   <= 1'b0;
      lstrb_qq  <= 1'b0;
      dir       <= 1'b0;
      step_busy <= 1'b0;
      step_cnt  <= '0;
      byte_cnt  <= '0;
      tach_cnt  <= '0;
      tach      <= 1'b0;
      track     <= '0;
      side      <= 1'b0;
      eject     <= 1'b0;
      motor     <= 1'b0;
      addr      <= '0;
      sense     <= 1'b1;
    end else begin
      lstrb_q  <= lstrb;
      lstrb_qq <= lstrb_q;
      side     <= sel;
      eject    <= 1'b0;
      sense    <= enable ? sv[{ca, sel}] : 1'b1;
      if (stb && reg_sel == 3'b000) dir <= ca[2];
      if (do_step) begin
        track     <= track_nxt;
        step_busy <= 1'b1;
        step_cnt  <= SW'(STEP_CYCLES - 1);
      end else if (step_busy) begin
        step_cnt <= step_cnt - SW'(1);
        if (step_cnt == '0) step_busy <= 1'b0;
      end
      if (stb && reg_sel == 3'b100 && inserted) motor <= ~ca[2];
      if (stb && reg_sel == 3'b110 && ca[2] && inserted) begin
        eject <= 1'b1;
        motor <= 1'b0;
      end
      if (spin) byte_cnt <= adv ? '0 : byte_cnt + BW'(1);
      if (adv) begin
        addr     <= addr >= lim - 14'd1 ? '0 : addr + 14'd1;
        tach_cnt <= tach_cnt == TW'(TACH_BYTES - 1) ? '0 : tach_cnt + TW'(1);
        if (tach_cnt == TW'(TACH_BYTES - 1)) tach <= ~tach;
      end
    end
  end
endmodule
